// File: rtl/trb_in_dispatch.sv
// Frame-level dispatcher: hands whole input frames round-robin to credit-limited turbo
// engines and logs each engine ID in an order queue so results can be drained in arrival order.
module trb_in_dispatch #(
  parameter int NUM_TURBO = 2,
  parameter int FRAME_LEN = 128,
  parameter int MAX_OUTST = 2,
  parameter int ORD_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           st_data_in,
  input  logic                 st_valid_in,
  input  logic                 st_sop_in,
  input  logic                 st_eop_in,
  output logic                 st_ready_out,
  output logic [7:0]           st_data_out,
  output logic [NUM_TURBO-1:0] st_valid_out,
  output logic                 st_sop_out,
  output logic                 st_eop_out,
  input  logic [NUM_TURBO-1:0] st_ready_in,
  input  logic [NUM_TURBO-1:0] eng_done_in,
  output logic [3:0]           ord_id_out,
  output logic                 ord_valid_out,
  input  logic                 ord_ready_in,
  output logic                 err_len,
  output logic                 err_sop,
  output logic                 err_credit
);

  localparam int CRD_W = $clog2(MAX_OUTST + 1);
  localparam int AW    = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_XFER} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sel_q, sel_d;
  logic [3:0]      rr_q;
  logic [10:0]     cnt_q, cnt_inc;
  logic [CRD_W-1:0] credit_q [NUM_TURBO];
  logic            quiet_q;

  logic [3:0]      ord_mem [ORD_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     ord_cnt_q;

  logic            err_len_q, err_sop_q, err_credit_q;

  logic            active, ready_sel, accept, first_beat, last_beat;
  logic            drop_idle, ord_full, ord_nempty, push, pop;
  logic            pick_ok;
  logic [3:0]      pick_id;
  logic [4:0]      idx;
  logic [NUM_TURBO-1:0] crd_inc, crd_err;

  assign active     = (state_q == S_XFER) && !rst;
  assign accept     = active && st_valid_in && ready_sel;
  assign first_beat = accept && (cnt_q == 11'd0);
  assign last_beat  = accept && st_eop_in;
  assign cnt_inc    = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
  assign ord_full   = (ord_cnt_q == (AW+1)'(ORD_DEPTH));
  assign ord_nempty = (ord_cnt_q != '0);
  assign push       = first_beat;
  assign pop        = ord_ready_in && ord_nempty && !rst;
  assign drop_idle  = (state_q == S_IDLE) && !quiet_q && !rst && st_valid_in && !st_sop_in;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ready_sel    = 1'b0;
    crd_inc      = '0;
    crd_err      = '0;
    st_valid_out = '0;
    for (int i = 0; i < NUM_TURBO; i++) begin
      if (sel_q == 4'(i)) begin
        ready_sel       = st_ready_in[i];
        crd_inc[i]      = first_beat;
        st_valid_out[i] = active && st_valid_in;
      end
      crd_err[i] = eng_done_in[i] && (credit_q[i] == '0);
    end
  end

  // Round-robin scan starting at rr_q; walking k downwards lets the nearest free engine win.
  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
    idx     = '0;
    for (int k = NUM_TURBO - 1; k >= 0; k--) begin
      idx = 5'(rr_q) + 5'(k);
      if (idx >= 5'(NUM_TURBO)) idx = idx - 5'(NUM_TURBO);
      for (int i = 0; i < NUM_TURBO; i++) begin
        if ((idx == 5'(i)) && (credit_q[i] < CRD_W'(MAX_OUTST))) begin
          pick_ok = 1'b1;
          pick_id = 4'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    st_ready_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!quiet_q && st_valid_in) begin
          if (st_sop_in) state_d = S_PICK;
          else           st_ready_out = 1'b1;
        end
      end
      S_PICK: begin
        if (pick_ok && !ord_full) begin
          state_d = S_XFER;
          sel_d   = pick_id;
        end
      end
      S_XFER: begin
        st_ready_out = ready_sel;
        if (last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) st_ready_out = 1'b0;
  end

  assign st_data_out   = active ? st_data_in : 8'd0;
  assign st_sop_out    = active && st_sop_in;
  assign st_eop_out    = active && st_eop_in;
  assign ord_valid_out = ord_nempty && !rst;
  assign ord_id_out    = (ord_nempty && !rst) ? ord_mem[rd_ptr_q] : 4'd0;
  assign err_len       = err_len_q && !rst;
  assign err_sop       = err_sop_q && !rst;
  assign err_credit    = err_credit_q && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      quiet_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ord_cnt_q    <= '0;
      err_len_q    <= 1'b0;
      err_sop_q    <= 1'b0;
      err_credit_q <= 1'b0;
      for (int i = 0; i < NUM_TURBO; i++) credit_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      quiet_q      <= 1'b0;
      err_len_q    <= last_beat && (cnt_inc != 11'(FRAME_LEN));
      err_sop_q    <= drop_idle || (accept && !first_beat && st_sop_in);
      err_credit_q <= |crd_err;

      if (last_beat) begin
        cnt_q <= '0;
        rr_q  <= (sel_q == 4'(NUM_TURBO - 1)) ? 4'd0 : sel_q + 4'd1;
      end else if (first_beat) begin
        cnt_q <= 11'd1;
      end else if (accept) begin
        cnt_q <= cnt_inc;
      end

      // A dispatch and a done on the same engine cancel; a done at zero credit is only flagged.
      for (int i = 0; i < NUM_TURBO; i++) begin
        case ({crd_inc[i], eng_done_in[i]})
          2'b10:   credit_q[i] <= credit_q[i] + CRD_W'(1);
          2'b01:   if (credit_q[i] != '0) credit_q[i] <= credit_q[i] - CRD_W'(1);
          default: credit_q[i] <= credit_q[i];
        endcase
      end

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   ord_cnt_q <= ord_cnt_q + (AW+1)'(1);
        2'b01:   ord_cnt_q <= ord_cnt_q - (AW+1)'(1);
        default: ord_cnt_q <= ord_cnt_q;
      endcase
    end
  end

  // NOTE: queue storage is not reset; the pointers and count define validity and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) ord_mem[wr_ptr_q] <= sel_q;
  end

endmodule

// File: tb/tb_trb_in_dispatch.sv
// Directed bench for trb_in_dispatch: a table of frames with expected engine and error
// outcomes, plus hand sequences for credit blocking, stray beats, credit errors and reset.
module tb_trb_in_dispatch;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    st_data_in;
  logic          st_valid_in, st_sop_in, st_eop_in;
  logic          st_ready_out;
  logic [7:0]    st_data_out;
  logic [NT-1:0] st_valid_out;
  logic          st_sop_out, st_eop_out;
  logic [NT-1:0] st_ready_in;
  logic [NT-1:0] eng_done_in;
  logic [3:0]    ord_id_out;
  logic          ord_valid_out, ord_ready_in;
  logic          err_len, err_sop, err_credit;

  trb_in_dispatch #(.NUM_TURBO(NT), .FRAME_LEN(128), .MAX_OUTST(2), .ORD_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .st_data_in(st_data_in), .st_valid_in(st_valid_in), .st_sop_in(st_sop_in),
    .st_eop_in(st_eop_in), .st_ready_out(st_ready_out),
    .st_data_out(st_data_out), .st_valid_out(st_valid_out), .st_sop_out(st_sop_out),
    .st_eop_out(st_eop_out), .st_ready_in(st_ready_in), .eng_done_in(eng_done_in),
    .ord_id_out(ord_id_out), .ord_valid_out(ord_valid_out), .ord_ready_in(ord_ready_in),
    .err_len(err_len), .err_sop(err_sop), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NT-1:0] v);
    int r = -1;
    for (int i = 0; i < NT; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({st_ready_out, st_valid_out, st_data_out, st_sop_out, st_eop_out,
                ord_id_out, ord_valid_out, err_len, err_sop, err_credit});
  endfunction

  // Engine-side monitor: rebuilds frames from accepted beats and counts error pulse cycles.
  int cur_len = 0, last_len = -1, last_eng = -1, data_err = 0;
  int n_err_len = 0, n_err_sop = 0, n_err_credit = 0;

  always @(negedge clk) begin
    if (err_len)    n_err_len    <= n_err_len + 1;
    if (err_sop)    n_err_sop    <= n_err_sop + 1;
    if (err_credit) n_err_credit <= n_err_credit + 1;
    if (rst) begin
      cur_len <= 0;
    end else if (|(st_valid_out & st_ready_in)) begin
      if ((st_data_out !== 8'(cur_len)) || (st_sop_out !== (cur_len == 0)))
        data_err <= data_err + 1;
      if (st_eop_out) begin
        last_len <= cur_len + 1;
        last_eng <= onehot_idx(st_valid_out);
        cur_len  <= 0;
      end else begin
        cur_len <= cur_len + 1;
      end
    end
  end

  int exp_ord[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source model: holds each beat until the dispatcher accepts it.
  task automatic send_frame(input int len, input bit toggle, input bit no_eop,
                            input logic [NT-1:0] done_first);
    int  cyc = 0;
    int  waited;
    bit  acc;
    for (int b = 0; b < len; b++) begin
      st_valid_in = 1'b1;
      st_data_in  = 8'(b);
      st_sop_in   = (b == 0);
      st_eop_in   = (b == len - 1) && !no_eop;
      waited = 0;
      acc    = 1'b0;
      while (!acc) begin
        if (toggle) st_ready_in = cyc[0] ? '1 : '0;
        cyc++;
        @(negedge clk);
        acc = st_ready_out;
        if (acc && b == 0) eng_done_in = done_first;
        tick();
        eng_done_in = '0;
        waited++;
        if (!acc && waited > 1000) begin
          check($sformatf("accept_timeout_beat%0d", b), 32'(waited), 32'(0));
          st_valid_in = 1'b0;
          st_ready_in = '1;
          return;
        end
      end
    end
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
    st_ready_in = '1;
  endtask

  typedef struct {
    int            len;
    bit            toggle;
    bit            done_after;
    logic [NT-1:0] done_first;
    int            exp_eng;
    int            exp_err_len;
  } row_t;

  row_t tbl [18];

  task automatic run_row(input int i);
    int b_len = n_err_len, b_sop = n_err_sop, b_cr = n_err_credit, b_de = data_err;
    send_frame(tbl[i].len, tbl[i].toggle, 1'b0, tbl[i].done_first);
    if (tbl[i].done_after) eng_done_in = NT'(1) << tbl[i].exp_eng;
    tick();
    eng_done_in = '0;
    tick();
    tick();
    check($sformatf("row%0d_engine", i),   32'(last_eng), 32'(tbl[i].exp_eng));
    check($sformatf("row%0d_length", i),   32'(last_len), 32'(tbl[i].len));
    check($sformatf("row%0d_err_len", i),  32'(n_err_len - b_len), 32'(tbl[i].exp_err_len));
    check($sformatf("row%0d_err_sop", i),  32'(n_err_sop - b_sop), 32'(0));
    check($sformatf("row%0d_err_cred", i), 32'(n_err_credit - b_cr), 32'(0));
    check($sformatf("row%0d_data", i),     32'(data_err - b_de), 32'(0));
    exp_ord.push_back(tbl[i].exp_eng);
  endtask

  task automatic drain(input string tag);
    while (exp_ord.size() > 0) begin
      ord_ready_in = 1'b1;
      @(negedge clk);
      check({tag, "_ord_valid"}, 32'(ord_valid_out), 32'(1));
      check({tag, "_ord_id"}, 32'(ord_id_out), 32'(exp_ord.pop_front()));
      tick();
      ord_ready_in = 1'b0;
    end
    @(negedge clk);
    check({tag, "_ord_empty"}, 32'(ord_valid_out), 32'(0));
    tick();
  endtask

  // Presents a sop and confirms the dispatcher refuses it for a number of cycles.
  task automatic expect_held(input string tag);
    bit seen = 1'b0;
    st_valid_in = 1'b1;
    st_sop_in   = 1'b1;
    st_eop_in   = 1'b0;
    st_data_in  = 8'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (st_ready_out || (|st_valid_out)) seen = 1'b1;
      tick();
    end
    check({tag, "_held"}, 32'(seen), 32'(0));
  endtask

  initial begin
    int b_sop, b_cr, b_len;

    // len, toggle, done_after, done_first, exp_eng, exp_err_len
    tbl[0]  = '{128, 1'b0, 1'b1, 2'b00, 0, 0};
    tbl[1]  = '{128, 1'b0, 1'b1, 2'b00, 1, 0};
    tbl[2]  = '{128, 1'b1, 1'b1, 2'b00, 0, 0};
    tbl[3]  = '{128, 1'b0, 1'b1, 2'b00, 1, 0};
    tbl[4]  = '{100, 1'b0, 1'b1, 2'b00, 0, 1};
    tbl[5]  = '{128, 1'b0, 1'b1, 2'b00, 1, 0};
    tbl[6]  = '{128, 1'b0, 1'b0, 2'b00, 0, 0};
    tbl[7]  = '{128, 1'b0, 1'b0, 2'b00, 1, 0};
    tbl[8]  = '{128, 1'b0, 1'b0, 2'b00, 0, 0};
    tbl[9]  = '{128, 1'b0, 1'b0, 2'b00, 1, 0};
    tbl[10] = '{128, 1'b0, 1'b0, 2'b00, 0, 0};
    tbl[11] = '{128, 1'b0, 1'b0, 2'b00, 1, 0};
    tbl[12] = '{128, 1'b0, 1'b0, 2'b01, 0, 0};
    tbl[13] = '{128, 1'b0, 1'b0, 2'b00, 1, 0};
    tbl[14] = '{128, 1'b0, 1'b0, 2'b00, 0, 0};
    tbl[15] = '{128, 1'b0, 1'b0, 2'b00, 0, 0};
    tbl[16] = '{128, 1'b0, 1'b0, 2'b00, 1, 0};
    tbl[17] = '{128, 1'b0, 1'b0, 2'b00, 0, 0};

    rst = 1'b1;
    st_data_in = 8'h3c; st_valid_in = 1'b1; st_sop_in = 1'b0; st_eop_in = 1'b0;
    st_ready_in = '1; eng_done_in = '0; ord_ready_in = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("reset_outputs", out_vec(), 32'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_quiet", out_vec(), 32'(0));
    tick();
    st_valid_in = 1'b0;
    tick();
    check("post_reset_err_sop", 32'(n_err_sop), 32'(0));

    // Back-to-back frames with prompt completion, including a half-rate ready engine.
    for (int i = 0; i < 4; i++) run_row(i);
    drain("t1");

    // Short frame then a normal one.
    for (int i = 4; i < 6; i++) run_row(i);
    drain("t4");

    // Stray non-sop beat while idle: accepted, dropped, flagged one cycle later for one cycle.
    b_sop = n_err_sop;
    st_valid_in = 1'b1; st_sop_in = 1'b0; st_data_in = 8'h55;
    @(negedge clk);
    check("stray_ready", 32'(st_ready_out), 32'(1));
    check("stray_not_forwarded", 32'(st_valid_out), 32'(0));
    tick();
    st_valid_in = 1'b0;
    @(negedge clk);
    check("stray_err_sop_on", 32'(err_sop), 32'(1));
    tick();
    @(negedge clk);
    check("stray_err_sop_off", 32'(err_sop), 32'(0));
    tick();
    check("stray_err_sop_count", 32'(n_err_sop - b_sop), 32'(1));

    // No completions: four frames fill both engines, the fifth waits for a done on engine 1.
    for (int i = 6; i < 10; i++) run_row(i);
    expect_held("t2");
    eng_done_in = 2'b10;
    tick();
    eng_done_in = '0;
    send_frame(128, 1'b0, 1'b0, 2'b00);
    tick();
    check("t2_fifth_engine", 32'(last_eng), 32'(1));
    check("t2_fifth_length", 32'(last_len), 32'(128));
    exp_ord.push_back(1);
    drain("t2");

    // Return all credit, then a done with no credit raises one err_credit cycle.
    eng_done_in = 2'b11;
    tick(); tick();
    eng_done_in = '0;
    tick();
    b_cr = n_err_credit;
    check("credit_drain_no_err", 32'(n_err_credit), 32'(0));
    eng_done_in = 2'b01;
    @(negedge clk);
    check("err_credit_not_early", 32'(err_credit), 32'(0));
    tick();
    eng_done_in = '0;
    @(negedge clk);
    check("err_credit_on", 32'(err_credit), 32'(1));
    tick();
    @(negedge clk);
    check("err_credit_off", 32'(err_credit), 32'(0));
    tick();
    check("err_credit_count", 32'(n_err_credit - b_cr), 32'(1));

    // Done on engine 0 coinciding with a dispatch to it leaves its credit at one, so
    // engine 0 takes exactly one more frame before both engines are full.
    for (int i = 10; i < 15; i++) run_row(i);
    drain("t5");
    expect_held("t5");
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Reset in the middle of a frame abandons it and clears credits, pointer and queue.
    b_len = n_err_len;
    send_frame(60, 1'b0, 1'b1, 2'b00);
    st_valid_in = 1'b1; st_sop_in = 1'b0; st_eop_in = 1'b0; st_data_in = 8'd60;
    rst = 1'b1;
    @(negedge clk);
    check("t6_outputs_in_reset", out_vec(), 32'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_outputs_after_reset", out_vec(), 32'(0));
    tick();
    st_valid_in = 1'b0;
    @(negedge clk);
    check("t6_queue_empty", 32'(ord_valid_out), 32'(0));
    tick();
    check("t6_no_err_len", 32'(n_err_len - b_len), 32'(0));
    for (int i = 15; i < 18; i++) run_row(i);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
